// File: rtl/prog_loader.sv
// prog_loader: streams instruction words into the i-cache from address 0, then raises start after a settle delay.
// Optional build macro PROG_LOADER_CHECKSUM_EN adds an expected-checksum gate before start.
module prog_loader #(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64,
  parameter int SETTLE = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic              s_valid,
  input  logic [31:0]       s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic [31:0]       i_instruction,
  output logic [ADDR_W-1:0] i_addr,
  output logic              i_wea,
  output logic              start,
  output logic              busy,
  output logic              error,
  output logic [ADDR_W:0]   words
`ifdef PROG_LOADER_CHECKSUM_EN
  ,
  input  logic [31:0]       exp_sum,
  output logic [31:0]       sum
`endif
);

  // state    | meaning
  // S_IDLE   | after reset, waiting for the first load_req
  // S_LOAD   | accepting stream words, one i-cache write per transfer
  // S_SETTLE | writes finished, settle down-counter running
  // S_RUN    | start held high, core fetching
  // S_ERR    | overflow or checksum mismatch, start held low
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETTLE, S_RUN, S_ERR} state_t;

  localparam logic [ADDR_W:0] LP_DEPTH  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LP_ONE    = (ADDR_W+1)'(1);
  localparam logic [3:0]      LP_SETTLE = 4'(SETTLE);

  state_t          r_state;
  logic [3:0]      r_cnt;
  logic            w_xfer;
  logic            w_full;
  logic            w_sum_bad;
  logic [ADDR_W:0] w_words_nxt;

  assign w_xfer      = s_valid && s_ready;
  assign w_words_nxt = words + LP_ONE;
  assign w_full      = (w_words_nxt == LP_DEPTH);

`ifdef PROG_LOADER_CHECKSUM_EN
  assign w_sum_bad = (sum != exp_sum);

  always_ff @(posedge clk) begin
    if (rst) begin
      sum <= '0;
    end else if (load_req && (r_state == S_IDLE || r_state == S_RUN || r_state == S_ERR)) begin
      sum <= '0;
    end else if (w_xfer) begin
      sum <= sum + s_data;
    end
  end
`else
  assign w_sum_bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      s_ready       <= 1'b0;
      i_instruction <= '0;
      i_addr        <= '0;
      i_wea         <= 1'b0;
      start         <= 1'b0;
      busy          <= 1'b0;
      error         <= 1'b0;
      words         <= '0;
    end else begin
      i_wea <= 1'b0;
      case (r_state)
        S_IDLE, S_RUN, S_ERR: begin
          if (load_req) begin
            r_state <= S_LOAD;
            s_ready <= 1'b1;
            busy    <= 1'b1;
            start   <= 1'b0;
            error   <= 1'b0;
            words   <= '0;
            i_addr  <= '0;
          end
        end
        S_LOAD: begin
          if (w_xfer) begin
            i_wea         <= 1'b1;
            i_instruction <= s_data;
            i_addr        <= words[ADDR_W-1:0];
            words         <= w_words_nxt;
            // s_last wins over the depth limit: a full program that ends exactly at DEPTH is legal
            if (s_last) begin
              r_state <= S_SETTLE;
              s_ready <= 1'b0;
              r_cnt   <= LP_SETTLE;
            end else if (w_full) begin
              r_state <= S_ERR;
              s_ready <= 1'b0;
              busy    <= 1'b0;
              error   <= 1'b1;
            end
          end
        end
        S_SETTLE: begin
          if (r_cnt == '0) begin
            busy <= 1'b0;
            if (w_sum_bad) begin
              r_state <= S_ERR;
              error   <= 1'b1;
            end else begin
              r_state <= S_RUN;
              start   <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Testbench for prog_loader: table of load scenarios plus randomized loads against a word-index reference model.
// Build with PROG_LOADER_CHECKSUM_EN to also exercise the checksum gate.
module tb_prog_loader;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;
  localparam int SETTLE = 2;

  logic              clk;
  logic              rst;
  logic              load_req;
  logic              s_valid;
  logic [31:0]       s_data;
  logic              s_last;
  logic              s_ready;
  logic [31:0]       i_instruction;
  logic [ADDR_W-1:0] i_addr;
  logic              i_wea;
  logic              start;
  logic              busy;
  logic              error;
  logic [ADDR_W:0]   words;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [31:0]       exp_sum;
  logic [31:0]       sum;
`endif

  prog_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst), .load_req(load_req),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .i_instruction(i_instruction), .i_addr(i_addr), .i_wea(i_wea),
    .start(start), .busy(busy), .error(error), .words(words)
`ifdef PROG_LOADER_CHECKSUM_EN
    , .exp_sum(exp_sum), .sum(sum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          n;
    bit          last;
    logic [15:0] pat;       // per-cycle s_valid pattern, 0 = random
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
    int          exp_words;
    bit          exp_err;
    bit          exp_start;
  } load_vec_t;

  load_vec_t tbl [6];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_s_ready"}, s_ready, 0);
    chk({tag, "_instr"}, i_instruction, 0);
    chk({tag, "_addr"}, i_addr, 0);
    chk({tag, "_wea"}, i_wea, 0);
    chk({tag, "_start"}, start, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_words"}, words, 0);
`ifdef PROG_LOADER_CHECKSUM_EN
    chk({tag, "_sum"}, sum, 0);
`endif
  endtask

  // Model: every offered word is accepted while loading; word k goes to address k one cycle later.
  task automatic run_load(input load_vec_t v, input bit bad_sum);
    logic [31:0] d [DEPTH+1];
    int idx;
    int cyc;
    bit loading;
    bit got_last;
    bit wr;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [31:0] msum;
`endif
    for (int k = 0; k <= DEPTH; k++)
      d[k] = (k == 0) ? v.w0 : (k == 1) ? v.w1 : (k == 2) ? v.w2 : $urandom;
`ifdef PROG_LOADER_CHECKSUM_EN
    msum = 0;
    for (int k = 0; k < v.n && k < DEPTH; k++) msum = msum + d[k];
    exp_sum = bad_sum ? msum + 32'd1 : msum;
`endif
    s_valid  = 1'b0;
    s_last   = 1'b0;
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    chk("ld_ready", s_ready, 1);
    chk("ld_busy", busy, 1);
    chk("ld_words", words, 0);
    chk("ld_error", error, 0);
    chk("ld_start", start, 0);
    idx = 0; cyc = 0; loading = 1'b1; got_last = 1'b0;
    while (loading && cyc < 2000) begin
      s_valid = (v.pat == 16'h0) ? ($urandom_range(0, 3) != 0) : v.pat[cyc % 16];
      s_data  = s_valid ? d[idx] : $urandom;
      s_last  = s_valid ? (v.last && (idx == v.n - 1)) : 1'($urandom_range(0, 1));
      wr = s_valid;
      tick();
      cyc++;
      chk("wea", i_wea, wr);
      if (wr) begin
        chk("addr", i_addr, idx);
        chk("instr", i_instruction, d[idx]);
        idx++;
        if (s_last) begin
          got_last = 1'b1;
          loading  = 1'b0;
        end else if (idx == DEPTH) begin
          loading = 1'b0;
        end
      end
      chk("words_run", words, idx);
      chk("ready_run", s_ready, loading);
    end
    chk("load_done", loading, 0);
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (got_last) begin
      for (int k = 1; k <= SETTLE + 1; k++) begin
        tick();
        chk("settle_wea", i_wea, 0);
        chk("settle_ready", s_ready, 0);
        if (k <= SETTLE) begin
          chk("settle_start", start, 0);
          chk("settle_busy", busy, 1);
        end else begin
          chk("run_start", start, !bad_sum);
          chk("run_busy", busy, 0);
          chk("run_error", error, bad_sum);
        end
      end
    end else begin
      chk("ovf_error", error, 1);
      chk("ovf_busy", busy, 0);
      for (int k = 0; k < 2; k++) begin
        s_valid = 1'b1;
        s_data  = $urandom;
        tick();
        chk("ovf_wea", i_wea, 0);
        chk("ovf_ready", s_ready, 0);
        chk("ovf_words", words, DEPTH);
        chk("ovf_start", start, 0);
      end
      s_valid = 1'b0;
    end
    chk("final_words", words, v.exp_words);
    chk("final_error", error, v.exp_err || bad_sum);
    chk("final_start", start, v.exp_start && !bad_sum);
`ifdef PROG_LOADER_CHECKSUM_EN
    chk("final_sum", sum, msum);
`endif
  endtask

  initial begin
    tbl[0] = '{3, 1'b1, 16'hFFFF, 32'h00000013, 32'h00100093, 32'h00208133, 3, 1'b0, 1'b1};
    tbl[1] = '{2, 1'b1, 16'hFFFF, 32'h0000000A, 32'h0000000B, 32'h0, 2, 1'b0, 1'b1};
    tbl[2] = '{3, 1'b1, 16'h0029, 32'h11111111, 32'h22222222, 32'h33333333, 3, 1'b0, 1'b1};
    tbl[3] = '{DEPTH + 1, 1'b0, 16'hFFFF, 32'h1, 32'h2, 32'h3, DEPTH, 1'b1, 1'b0};
    tbl[4] = '{1, 1'b1, 16'h0000, 32'hDEADBEEF, 32'h0, 32'h0, 1, 1'b0, 1'b1};
    tbl[5] = '{DEPTH, 1'b1, 16'hFFFF, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h0, DEPTH, 1'b0, 1'b1};

    rst = 1'b1; load_req = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
    exp_sum = '0;
`endif
    tick();
    tick();
    check_reset("por");
    rst = 1'b0;
    s_valid = 1'b1;
    tick();
    chk("idle_wea", i_wea, 0);
    chk("idle_ready", s_ready, 0);
    s_valid = 1'b0;

    for (int t = 0; t < 6; t++) run_load(tbl[t], 1'b0);

    // reset mid-load, with an ignored load_req on the third word
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    for (int k = 0; k < 5; k++) begin
      s_valid  = 1'b1;
      s_data   = $urandom;
      s_last   = 1'b0;
      load_req = (k == 2);
      tick();
      chk("mid_wea", i_wea, 1);
      chk("mid_addr", i_addr, k);
      chk("mid_words", words, k + 1);
      chk("mid_busy", busy, 1);
    end
    load_req = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    s_valid = 1'b0;
    check_reset("midrst");
    run_load(tbl[1], 1'b0);

    for (int r = 0; r < 8; r++) begin
      load_vec_t v;
      v.n         = (r == 3) ? DEPTH + 1 : int'($urandom_range(1, DEPTH));
      v.last      = (r != 3);
      v.pat       = 16'h0;
      v.w0        = $urandom;
      v.w1        = $urandom;
      v.w2        = $urandom;
      v.exp_words = v.last ? v.n : DEPTH;
      v.exp_err   = !v.last;
      v.exp_start = v.last;
      run_load(v, 1'b0);
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    begin
      load_vec_t c;
      c = '{3, 1'b1, 16'hFFFF, 32'd1, 32'd2, 32'd3, 3, 1'b0, 1'b1};
      run_load(c, 1'b0);
      run_load(c, 1'b1);
      run_load(c, 1'b0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected summary before time limit");
    $fatal(1);
  end

endmodule
